// File: rtl/td4_core.sv
// td4_core: single-cycle TD4-style 4-bit core; fetches ROM[pc] and executes it on each enabled edge
module td4_core (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       en,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [3:0] in_port,
  output logic [3:0] out_port,
  output logic       carry
);
  logic [3:0] a, b, pc, op, im, src;
  logic [4:0] sum;
  logic       wa, wb, wo, jmp;
  assign rom_addr = pc;
  assign op = rom_data[7:4];
  assign im = rom_data[3:0];
  // undefined opcodes fall through to a zero source, so they can never raise carry
  always_comb begin
    src = (op == 4'h0 || op == 4'h4) ? a :
          (op == 4'h1 || op == 4'h5 || op == 4'h9) ? b :
          (op == 4'h2 || op == 4'h6) ? in_port : 4'h0;
    sum = {1'b0, src} + {1'b0, im};
    wa  = op[3:2] == 2'b00;
    wb  = op[3:2] == 2'b01;
    wo  = op == 4'h9 || op == 4'hB;
    jmp = op == 4'hF || (op == 4'hE && !carry);
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pc       <= 4'h0;
      a        <= 4'h0;
      b        <= 4'h0;
      out_port <= 4'h0;
      carry    <= 1'b0;
    end else if (en) begin
      pc    <= jmp ? sum[3:0] : pc + 4'd1;
      carry <= sum[4];
      if (wa) a <= sum[3:0];
      if (wb) b <= sum[3:0];
      if (wo) out_port <= sum[3:0];
    end
  end
endmodule

// File: tb/tb_td4_core.sv
// tb_td4_core: directed and random programs checked against an opcode-level reference model
module tb_td4_core;
  logic       clk = 0, n_reset = 0, en = 0, carry;
  logic [3:0] rom_addr, in_port = 0, out_port;
  logic [7:0] rom_data;
  logic [7:0] rom [16];
  int total = 0, bad = 0;
  int ma, mb, mo, mpc, mc;

  td4_core dut (
    .clk(clk), .n_reset(n_reset), .en(en), .rom_addr(rom_addr), .rom_data(rom_data),
    .in_port(in_port), .out_port(out_port), .carry(carry)
  );

  assign rom_data = rom[rom_addr];
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, rom_addr, 4'(mpc));
    check({tag, ".out"}, out_port, 4'(mo));
    check({tag, ".c"}, {3'b0, carry}, 4'(mc));
    check({tag, ".a"}, dut.a, 4'(ma));
    check({tag, ".b"}, dut.b, 4'(mb));
  endtask

  task automatic model_reset();
    ma = 0; mb = 0; mo = 0; mpc = 0; mc = 0;
  endtask

  task automatic model_step();
    int op, im, s, inp;
    bit jump;
    op = rom[mpc] >> 4;
    im = rom[mpc] & 15;
    inp = int'(in_port);
    jump = 0;
    case (op)
      0:  begin s = ma + im;  ma = s % 16; end
      1:  begin s = mb + im;  ma = s % 16; end
      2:  begin s = inp + im; ma = s % 16; end
      3:  begin s = im;       ma = s; end
      4:  begin s = ma + im;  mb = s % 16; end
      5:  begin s = mb + im;  mb = s % 16; end
      6:  begin s = inp + im; mb = s % 16; end
      7:  begin s = im;       mb = s; end
      9:  begin s = mb + im;  mo = s % 16; end
      11: begin s = im;       mo = s; end
      14: begin s = im; jump = (mc == 0); end
      15: begin s = im; jump = 1; end
      default: s = 0;
    endcase
    mc = s / 16;
    mpc = jump ? s % 16 : (mpc + 1) % 16;
  endtask

  task automatic step(input logic e, input string tag);
    en = e;
    @(posedge clk);
    if (e) model_step();
    #1;
    check_all(tag);
  endtask

  task automatic load(input logic [7:0] p [16]);
    for (int i = 0; i < 16; i++) rom[i] = p[i];
  endtask

  task automatic restart();
    @(negedge clk);
    n_reset = 0;
    #1;
    model_reset();
    check_all("restart");
    n_reset = 1;
  endtask

  initial begin
    logic [7:0] p [16];
    for (int i = 0; i < 16; i++) p[i] = 8'h00;
    p[0] = 8'h70; p[1] = 8'h90; p[2] = 8'h51; p[3] = 8'hF1;
    load(p);
    model_reset();
    en = 1;
    #2;
    check_all("rst_hold");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_all("rst_clk");
    end
    n_reset = 1;
    // counter program: 16 out values plus the wrap
    for (int i = 0; i < 52; i++) step(1, "counter");
    @(posedge clk); model_step(); #2;
    n_reset = 0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    n_reset = 1;

    for (int i = 0; i < 16; i++) p[i] = 8'h00;
    p[0] = 8'h3F; p[1] = 8'h01; p[2] = 8'hE5; p[3] = 8'hBA;
    p[4] = 8'hF4; p[5] = 8'hB5; p[6] = 8'hF6;
    load(p);
    restart();
    for (int i = 0; i < 7; i++) step(1, "jnc_nt");
    check("jnc_nt.final_out", out_port, 4'hA);
    p[0] = 8'h30;
    load(p);
    restart();
    for (int i = 0; i < 7; i++) step(1, "jnc_t");
    check("jnc_t.final_out", out_port, 4'h5);

    for (int i = 0; i < 16; i++) p[i] = 8'h00;
    p[0] = 8'h20; p[1] = 8'h40; p[2] = 8'h93; p[3] = 8'h62;
    load(p);
    restart();
    in_port = 4'hA;
    for (int i = 0; i < 3; i++) step(1, "in_mov");
    check("in_mov.out13", out_port, 4'hD);
    in_port = 4'hF;
    step(1, "in_b");
    check("in_b.carry", {3'b0, carry}, 4'h1);

    for (int i = 0; i < 16; i++) p[i] = 8'h00;
    load(p);
    restart();
    for (int i = 0; i < 16; i++) begin
      step(1, "en1"); step(0, "en0"); step(0, "en0"); step(1, "en1");
    end
    check("en.wrap_pc", rom_addr, 4'h0);

    p[0] = 8'h05; p[1] = 8'h8F; p[2] = 8'hAF; p[3] = 8'hCF; p[4] = 8'hDF;
    load(p);
    restart();
    for (int i = 0; i < 5; i++) step(1, "undef");
    check("undef.pc5", rom_addr, 4'h5);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) p[i] = 8'($urandom);
      load(p);
      restart();
      for (int i = 0; i < 60; i++) begin
        in_port = 4'($urandom);
        step(1'($urandom_range(0, 3) != 0), "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/td4_core.md
# td4_core

Four-bit TD4-style execution core that fetches one 8-bit instruction per enabled clock from the 16-entry program ROM and executes it in that same cycle. It sits directly downstream of the program ROM. Its program counter drives the ROM address bus, and it consumes the ROM data byte as the current instruction. It holds registers A and B, the output latch, the carry flag and the program counter, and drives the board-level 4-bit input and output ports.

## Interface
- No parameters. All widths are fixed by the ISA: 4-bit data, 4-bit address, 8-bit instruction.
- clk  input  1  system clock; all state updates on its rising edge.
- n_reset  input  1  reset, asynchronous and active-low.
- en  input  1  step enable; when 0, all state holds.
- rom_addr  output  4  instruction address to ROM; equals PC.
- rom_data  input  8  instruction from ROM: [7:4] opcode, [3:0] immediate (im).
- in_port  input  4  external input switches, sampled by IN instructions.
- out_port  output  4  output latch.
- carry  output  1  current carry flag, exported for debug.

## Operation
- State: A[3:0], B[3:0], OUT[3:0], PC[3:0], C (carry).
- Every instruction computes a 5-bit sum: {cout, res} = src + im.
  - src is A, B, in_port or 0, selected by opcode.
  - The sum is zero-extended to 5 bits; cout is bit 4.
- Opcode decode (src → destination):
  - 0000 ADD A,im: A → A.
  - 0001 MOV A,B: B → A.
  - 0010 IN A: in_port → A.
  - 0011 MOV A,im: 0 → A.
  - 0100 MOV B,A: A → B.
  - 0101 ADD B,im: B → B.
  - 0110 IN B: in_port → B.
  - 0111 MOV B,im: 0 → B.
  - 1001 OUT B: B → OUT.
  - 1011 OUT im: 0 → OUT.
  - 1110 JNC im: 0 → PC, taken only if C==0 before this instruction.
  - 1111 JMP im: 0 → PC, always taken.
- Undefined opcodes (1000, 1010, 1100, 1101) execute as NOP: no register or OUT write.
- MOV A,B, IN, MOV B,A and OUT B add im to their source; im is not ignored. With im=0 they are plain moves.
- Carry:
  - C ← cout for every defined opcode, including JMP, JNC and OUT im (cout is always 0 for those).
  - C ← 0 for undefined opcodes.
- PC: if a jump is taken, PC ← res; otherwise PC ← PC+1 mod 16. 15 wraps to 0.
- JNC tests the old C. The C written by the JNC itself is 0.
- Register writes wrap modulo 16; overflow appears only in C.

## Timing
- Single-cycle execution. rom_addr = PC combinationally. The ROM is combinational, so the instruction is valid in the same cycle.
- On a rising clk with en=1, the new PC, destination register and C all commit together.
- With en=0: PC, A, B, OUT and C all hold; outputs are stable.
- Reset:
  - While n_reset==0, regardless of clk or en: PC=0, A=0, B=0, OUT=0, C=0, so rom_addr=0, out_port=0, carry=0.
  - Asserting n_reset mid-program takes effect immediately, without waiting for a clock.
  - On release, the first enabled edge executes ROM[0].
- in_port is sampled only at the enabling edge of an IN instruction; it need not be synchronised by this block.
- out_port changes only on an edge that executes OUT B or OUT im. It holds across all other instructions.
- Latency: instruction at address n affects out_port one enabled edge after PC becomes n.

## Test plan
- Reset behaviour: hold n_reset=0, toggle clk with en=1 → PC, out_port and carry stay 0. Assert n_reset low asynchronously mid-run (between edges) → all state is 0 before the next edge.
- Counter program (ROM 0:0x70, 1:0x90, 2:0x51, 3:0xF1, rest 0x00), en=1:
  - out_port steps 0,1,2,…,15,0 every 3 cycles.
  - carry=1 for exactly the cycle after B wraps 15→0.
  - PC sequence is 0,1,2,3,1,2,3,….
- Carry and JNC: ROM 0:0x3F (mov a,15), 1:0x01 (add a,1), 2:0xE5 (jnc 5), 3:0xBA (out 10), 4:0xF4 (jmp 4), 5:0xB5 (out 5), 6:0xF6 (jmp 6).
  - Expect A=0, C=1 after addr 1; JNC not taken; out_port=10; then looping at 4.
  - Change addr 0 to 0x30 → JNC taken; out_port=5; then looping at 6.
- IN and moves: in_port=0xA, ROM 0x20 (in a), 0x40 (mov b,a), 0x93 (out b with im=3) → A=10, B=10, out_port=13, C=0. Then drive in_port=0xF with 0x62 → B=1, C=1.
- Enable gating and wrap: ROM all 0x00 (add a,0), toggle en in the pattern 1,0,0,1 → PC advances only on en=1 edges. After 16 enabled steps PC returns to 0. A stays 0.
- Undefined opcodes: ROM 0:0x05 (add a,5), 1:0x8F, 2:0xAF, 3:0xCF, 4:0xDF → A stays 5, out_port stays 0, C=0, PC reaches 5.
